// File: rtl/sequence_detector_101_moore.sv
// Moore FSM that flags each "101" seen on a serial bit stream.
// OVERLAP selects whether the trailing '1' of a match may begin the next one.
module sequence_detector_101_moore #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);

  typedef enum logic [1:0] {
    S0 = 2'd0,  // nothing useful seen
    S1 = 2'd1,  // "1" seen
    S2 = 2'd2,  // "10" seen
    S3 = 2'd3   // "101" seen
  } state_t;

  state_t r_state;
  logic   r_y;

  // r_y is registered alongside the state so it is high exactly while r_state == S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
      r_y     <= 1'b0;
    end else begin
      r_y <= 1'b0;
      case (r_state)
        S0: r_state <= x ? S1 : S0;
        S1: r_state <= x ? S1 : S2;
        S2: begin
          if (x) begin
            r_state <= S3;
            r_y     <= 1'b1;
          end else begin
            r_state <= S0;
          end
        end
        S3: begin
          if (x)
            r_state <= S1;
          else
            r_state <= OVERLAP ? S2 : S0;
        end
        default: r_state <= S0;
      endcase
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_sequence_detector_101_moore.sv
// Drives both OVERLAP variants with one stream and checks each against
// a history-based reference model (last three bits since the last restart).
module tb_sequence_detector_101_moore;

  logic clk;
  logic rst;
  logic x;
  logic y_ov;
  logic y_no;

  int n_assert = 0;
  int n_fail   = 0;
  int n_step   = 0;

  // Reference model: recent bits and how many are valid since reset (or since last match when non-overlapping).
  logic [2:0] h_ov, h_no;
  int         c_ov, c_no;
  logic       e_ov, e_no;

  sequence_detector_101_moore #(.OVERLAP(1'b1)) u_ov (
    .clk(clk), .rst(rst), .x(x), .y(y_ov)
  );

  sequence_detector_101_moore #(.OVERLAP(1'b0)) u_no (
    .clk(clk), .rst(rst), .x(x), .y(y_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic b, input logic r, input string tag);
    x   = b;
    rst = r;
    @(posedge clk);
    #1;
    n_step++;
    if (r) begin
      c_ov = 0; c_no = 0;
      h_ov = 3'b000; h_no = 3'b000;
      e_ov = 1'b0; e_no = 1'b0;
    end else begin
      h_ov = {h_ov[1:0], b};
      h_no = {h_no[1:0], b};
      c_ov = (c_ov < 3) ? c_ov + 1 : 3;
      c_no = (c_no < 3) ? c_no + 1 : 3;
      e_ov = (c_ov == 3) && (h_ov == 3'b101);
      e_no = (c_no == 3) && (h_no == 3'b101);
      if (e_no) c_no = 0;
    end
    n_assert++;
    assert (y_ov === e_ov) else begin
      n_fail++;
      $error("FAIL %s ov step %0d x=%0b rst=%0b: y=%0b expected %0b", tag, n_step, b, r, y_ov, e_ov);
    end
    n_assert++;
    assert (y_no === e_no) else begin
      n_fail++;
      $error("FAIL %s no step %0d x=%0b rst=%0b: y=%0b expected %0b", tag, n_step, b, r, y_no, e_no);
    end
    $display("step %0d %s rst=%0b x=%0b y_ov=%0b(exp %0b) y_no=%0b(exp %0b)",
             n_step, tag, r, b, y_ov, e_ov, y_no, e_no);
  endtask

  task automatic run_seq(input logic [15:0] bits, input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) step(bits[i], 1'b0, tag);
  endtask

  initial begin
    rst = 1'b1;
    x   = 1'b0;
    c_ov = 0; c_no = 0;
    h_ov = 3'b000; h_no = 3'b000;
    e_ov = 1'b0; e_no = 1'b0;

    // Reset hold with x toggling
    step(1'b1, 1'b1, "rst_hold");
    step(1'b0, 1'b1, "rst_hold");

    // 1010101: pulses after 3rd, 5th, 7th (overlap); only 3rd and 7th... non-overlap per model
    run_seq(16'b1010101, 7, "alt");

    step(1'b0, 1'b1, "rst");
    run_seq(16'b11101, 5, "ones_run");
    run_seq(16'b1001, 4, "zeros_run");

    step(1'b0, 1'b1, "rst");
    run_seq(16'b10101, 5, "nonov_a");
    run_seq(16'b101, 3, "nonov_b");

    step(1'b0, 1'b1, "rst");
    run_seq(16'b101101, 6, "s3_one");

    // Reset mid-sequence discards "10"
    run_seq(16'b10, 2, "mid");
    step(1'b1, 1'b1, "mid_rst");
    step(1'b1, 1'b0, "mid_after");

    // Reset while y is high
    step(1'b0, 1'b1, "rst");
    run_seq(16'b101, 3, "yhi");
    step(1'b1, 1'b1, "yhi_rst");

    // Random stream with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(1, 0)), ($urandom_range(29, 0) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
